// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers
//
// Purpose: one shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle. Signed operands are reduced to magnitudes on entry and the signs
// are reapplied in a single FIX cycle. HI/LO only change in FIX, on MTHI/MTLO
// while idle, or on reset.
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   defined   - multiplies leave CALC as soon as the remaining multiplier
//               bits are all zero; FIX right-aligns the partial product.
//   undefined - every operation runs exactly ITERS iterations.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, op       begin operation (IDLE only); 00 MULTU 01 MULT 10 DIVU 11 DIV
//   a, b            rs / rt operands
//   mthi, mtlo      write wdata to HI / LO (IDLE only, start has priority)
//   wdata           MTHI/MTLO data
//   busy            operation in progress
//   done            one-cycle pulse after HI/LO are written by an operation
//   div_by_zero     sticky, set by divide with b==0, cleared by next start
//   hi, lo          HI / LO registers
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITERS) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // negate product / quotient in FIX
  logic               rneg_q, rneg_d;   // negate remainder in FIX
  logic               zero_q, zero_d;   // divide by zero in flight
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;   // product, or remainder:quotient
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;
  logic               early;
  logic [2*WIDTH-1:0] fix_prod;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   quot, rem;

  always_comb begin
    // Negating the most negative value wraps to itself, which is the correct
    // unsigned magnitude.
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // Multiply step: add on multiplier LSB, then shift right including carry.
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = prod_q[0] ? {mul_sum, prod_q[WIDTH-1:1]}
                         : {1'b0, prod_q[2*WIDTH-1:1]};

    // Restoring divide step; the shifted remainder needs one extra bit.
    div_shift = prod_q[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    div_next  = div_ge ? {div_diff, prod_q[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};

    last_iter = (cnt_q == CW'(ITERS - 1));

`ifdef MDU_EARLY_OUT_EN
    // Unconsumed multiplier bits sit below the partial product in the low
    // half; once they are all zero the remaining steps would only shift.
    early    = !div_q && ((mul_next[WIDTH-1:0] & ({WIDTH{1'b1}} >> (cnt_q + CW'(1)))) == '0);
    fix_prod = prod_q >> (CW'(ITERS) - cnt_q);
`else
    early    = 1'b0;
    fix_prod = prod_q;
`endif

    mul_res = neg_q  ? -fix_prod : fix_prod;
    quot    = neg_q  ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem     = rneg_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    opnd_d  = opnd_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d  = '0;
          div_d  = op[1];
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          zero_d = op[1] && (b == '0);
          dbz_d  = 1'b0;
          if (op[1]) begin
            opnd_d = b_mag;
            // Divide by zero parks the original dividend in the upper half.
            prod_d = (b == '0) ? {a, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            prod_d = {{WIDTH{1'b0}}, b_mag};
          end
          state_d = (op[1] && (b == '0)) ? FIX : CALC;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      CALC: begin
        prod_d = div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_iter || early) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (zero_q) begin
          hi_d  = prod_q[2*WIDTH-1:WIDTH];
          lo_d  = {WIDTH{1'b1}};
          dbz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = mul_res[2*WIDTH-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      opnd_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      opnd_q  <= opnd_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_dbz;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected number of edges from the start edge until done is visible.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    if (o[1] && y == 32'd0) return 1;
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) begin
      logic [31:0] mag;
      int idx;
      mag = (o[0] && y[31]) ? (32'd0 - y) : y;
      idx = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
      return 2 + idx;
    end
`endif
    return 33;
  endfunction

  task automatic model(input logic [1:0] o, input logic [31:0] x, y,
                       output logic [31:0] eh, el, output logic ez);
    logic [63:0] p;
    longint sx, sy, q, r;
    ez = 1'b0;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin p = {32'd0, x} * {32'd0, y}; eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          eh = x; el = 32'hFFFF_FFFF; ez = 1'b1;
        end else if (o == 2'b10) begin
          el = x / y; eh = x % y;
        end else begin
          q = sx / sy; r = sx % sy;
          el = q[31:0]; eh = r[31:0];
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, y,
                       input int mt_at, input logic mthi_with_start, input string tag);
    logic [31:0] eh, el;
    logic        ez, held;
    int          lat, edges, busy_cycles;
    model(o, x, y, eh, el, ez);
    lat = exp_lat(o, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    mthi = mthi_with_start; wdata = 32'hBAD0_0BAD;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check($sformatf("%s_accept", tag), {62'd0, busy, done}, 64'd2);
    edges = 0; busy_cycles = 0; held = 1'b1;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      if (hi !== m_hi || lo !== m_lo) held = 1'b0;
      mtlo  = (edges == mt_at);
      wdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      edges++;
    end
    mtlo = 1'b0;
    check($sformatf("%s_latency", tag), 64'(edges), 64'(lat));
    check($sformatf("%s_busy_cycles", tag), 64'(busy_cycles), 64'(lat));
    check($sformatf("%s_hold", tag), {63'd0, held}, 64'd1);
    check($sformatf("%s_hi", tag), {32'd0, hi}, {32'd0, eh});
    check($sformatf("%s_lo", tag), {32'd0, lo}, {32'd0, el});
    check($sformatf("%s_dbz", tag), {63'd0, div_by_zero}, {63'd0, ez});
    check($sformatf("%s_idle", tag), {63'd0, busy}, 64'd0);
    m_hi = eh; m_lo = el; m_dbz = ez;
  endtask

  task automatic mt_write(input logic wh, wl, input logic [31:0] v, input string tag);
    @(negedge clk);
    mthi = wh; mtlo = wl; wdata = v;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (wh) m_hi = v;
    if (wl) m_lo = v;
    check($sformatf("%s_hi", tag), {32'd0, hi}, {32'd0, m_hi});
    check($sformatf("%s_lo", tag), {32'd0, lo}, {32'd0, m_lo});
  endtask

  initial begin
    logic saw_done;
    logic [31:0] rx, ry;
    int sel;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    mt_write(1'b1, 1'b0, 32'h0000_1234, "mthi");
    do_op(2'b00, 32'd2, 32'd3, 10, 1'b0, "multu_2x3_mtlo");
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, "multu_max");
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, -1, 1'b0, "mult_m3x7");
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, "mult_minmin");
    do_op(2'b01, 32'd12345, 32'd0, -1, 1'b0, "mult_b0");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, "div_m7_2");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, "div_wrap");
    do_op(2'b10, 32'd100, 32'd0, -1, 1'b0, "divu_by0");
    do_op(2'b10, 32'd100, 32'd3, -1, 1'b1, "divu_100_3");
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, -1, 1'b0, "div_7_m2");
    mt_write(1'b1, 1'b1, 32'hAAAA_5555, "mt_both");

    // Reset during cycle 15 of a MULTU with preloaded HI/LO.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    saw_done = done;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    do_op(2'b00, 32'd5, 32'd9, -1, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: ry = 32'd0;
        1: ry = 32'd1;
        2: ry = 32'hFFFF_FFFF;
        3: ry = 32'h8000_0000;
        4: ry = $urandom_range(0, 15);
        default: ry = $urandom;
      endcase
      rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      do_op(2'($urandom_range(0, 3)), rx, ry, -1, 1'b0, $sformatf("rand%0d", i));
    end

    @(posedge clk); #1;
    check("final_done_low", {63'd0, done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the combinational barrel shifter.
- Implements MULT, MULTU, DIV and DIVU using one shift-add / shift-subtract step per cycle, plus the architectural HI/LO registers.
- Takes the same rs/rt operands as the shifter.
- HI/LO values feed the same execute result mux for MFHI/MFLO. The control unit stalls the pipeline on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITERS, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- mthi  input  1  write wdata to HI; honoured only in IDLE
- mtlo  input  1  write wdata to LO; honoured only in IDLE
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when HI/LO are updated
- div_by_zero  output  1  sticky flag; set by a divide with b==0, cleared by the next accepted start
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE, iteration counter to 0.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Reset mid-operation aborts the operation; no HI/LO update occurs.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at a clock edge latches op, a and b, moves to CALC and sets busy=1.
  - For signed ops, sign bits are captured and the operands are converted to magnitudes; 0x80000000 is kept as unsigned magnitude 0x80000000.
  - For a divide with b==0, the block goes directly to FIX instead of CALC.
- CALC, multiply: 2*WIDTH product register. Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper half, then shift the whole register right 1, carry included.
- CALC, divide: restoring division. Each cycle, shift remainder:quotient left 1, then trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- CALC to FIX after exactly ITERS iterations (counter 0..ITERS-1).
- FIX, one cycle:
  - Signed multiply: negate the 64-bit product if the signs differ.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Multiply writes hi=product[63:32], lo=product[31:0]. Divide writes lo=quotient, hi=remainder.
  - Divide by zero writes hi=a (original value, unchanged), lo=0xFFFFFFFF, div_by_zero=1.
  - On the same edge: done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - Normal operation: done is high in the cycle that starts ITERS+1 edges after the start edge (start sampled at edge 0, done visible after edge 33).
  - Divide by zero: done is visible after edge 1.
- hi and lo hold their old values throughout an operation; they change only in FIX, on MTHI/MTLO, or on reset.
- start, mthi and mtlo asserted while busy are ignored.
- start together with mthi or mtlo in IDLE: start wins and the MT write is dropped.
- mthi and mtlo together: both registers take wdata.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- A new start is accepted in the cycle done is high, because the state is already IDLE.

Optional Feature:
- MDU_EARLY_OUT_EN, multiply operations only:
  - Defined: CALC moves to FIX as soon as the remaining multiplier bits are all zero. The product register is right-aligned by the remaining iteration count in FIX. Latency is therefore 2 + (index of highest set bit of |b|) edges, with a minimum of 2 when b==0. Results are identical.
  - Undefined: fixed ITERS iterations for all operations.
- Divide latency is the same with or without the macro.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001, done one cycle after edge 33, busy high for 33 cycles.
- MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; with MDU_EARLY_OUT_EN, done after edge 4.
- DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100 b=0 → done after edge 1, hi=100, lo=0xFFFFFFFF, div_by_zero=1; the next start with b=3 clears div_by_zero and gives lo=33, hi=1.
- MTHI 0x1234 in IDLE → hi=0x1234. Then MULTU 2×3 with mtlo=1 pulsed at cycle 10 → lo=6 and hi=0 at done; the mtlo pulse is ignored.
- rst asserted at cycle 15 of a MULTU with preloaded hi/lo → next cycle busy=0, hi=0, lo=0, no done pulse; a following start runs normally.
